// File: rtl/fetch_pc_ctrl_pkg.sv
// Fetch PC controller shared types: FSM states, next-PC select codes,
// default reset/trap vectors and an alignment helper.
package fetch_pc_ctrl_pkg;

  typedef enum logic [1:0] {
    FPC_RUN  = 2'd0,
    FPC_WAIT = 2'd1,
    FPC_HOLD = 2'd2
  } fpc_state_e;

  typedef enum logic [1:0] {
    NPC_SEQ  = 2'd0,  // pcF + 4
    NPC_KEEP = 2'd1,  // hold pcF
    NPC_TGT  = 2'd2,  // execute-stage redirect (alignment-fixed)
    NPC_TGTQ = 2'd3   // redirect latched while a beat was outstanding
  } npc_sel_e;

  localparam logic [31:0] FPC_RESET_PC = 32'h0000_0000;
  localparam logic [31:0] FPC_TRAP_VEC = 32'h0000_0100;

  function automatic logic is_misaligned(input logic [31:0] addr);
    return addr[1:0] != 2'b00;
  endfunction

endpackage

// File: rtl/fetch_pc_ctrl_if.sv
// Instruction-memory request handshake between fetch and imem.
interface fetch_pc_ctrl_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;

  modport master (output imem_req, output imem_addr, input imem_ready);
  modport slave  (input imem_req, input imem_addr, output imem_ready);
endinterface

// File: rtl/fetch_pc_ctrl_pc_next_mux.sv
// Next-PC selection and redirect target alignment fix-up.
// MISALIGN_TRAP_EN: misaligned targets become TRAP_VEC; otherwise the
// low two target bits are simply cleared.
import fetch_pc_ctrl_pkg::*;

module pc_next_mux #(
  parameter logic [31:0] TRAP_VEC = FPC_TRAP_VEC
) (
  input  npc_sel_e    sel,
  input  logic [31:0] pc,
  input  logic [31:0] target,
  input  logic [31:0] tgt_q,
  output logic [31:0] pc_next,
  output logic [31:0] tgt_eff,
  output logic        misaligned
);

`ifdef MISALIGN_TRAP_EN
  localparam bit TRAP_EN = 1'b1;
`else
  localparam bit TRAP_EN = 1'b0;
`endif

  // Clearing bits[1:0] is a no-op for aligned targets, so one expression
  // covers both the aligned case and the no-trap fix-up.
  always_comb begin
    misaligned = is_misaligned(target);
    tgt_eff    = (TRAP_EN && misaligned) ? TRAP_VEC : {target[31:2], 2'b00};
  end

  // Next-PC source select.
  always_comb begin
    pc_next = pc;
    case (sel)
      NPC_SEQ:  pc_next = pc + 32'd4;
      NPC_KEEP: pc_next = pc;
      NPC_TGT:  pc_next = tgt_eff;
      NPC_TGTQ: pc_next = tgt_q;
      default:  pc_next = pc;
    endcase
  end

endmodule

// File: rtl/fetch_pc_ctrl.sv
// Fetch-stage PC owner: drives the imem handshake, applies execute-stage
// redirects (deferred into HOLD while a beat is outstanding, with the
// wrong-path beat dropped), and raises flushD/flushE.
// Optional feature macro: MISALIGN_TRAP_EN (misaligned targets trap to TRAP_VEC).
import fetch_pc_ctrl_pkg::*;

module fetch_pc_ctrl #(
  parameter logic [31:0] RESET_PC = FPC_RESET_PC,
  parameter logic [31:0] TRAP_VEC = FPC_TRAP_VEC
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   br_selE,
  input  logic [31:0]            pc_targetE,
  input  logic                   stallF,
  fetch_pc_ctrl_if.master        imem,
  output logic [31:0]            pcF,
  output logic [31:0]            pc_plus4F,
  output logic                   instr_validF,
  output logic                   flushD,
  output logic                   flushE,
  output logic                   misalign_exc
);

`ifdef MISALIGN_TRAP_EN
  localparam bit TRAP_EN = 1'b1;
`else
  localparam bit TRAP_EN = 1'b0;
`endif

  fpc_state_e  state, state_n;
  npc_sel_e    sel;
  logic        req_q, drop, latch_tgt, beat, acc, misaligned;
  logic [31:0] tgt_q, tgt_eff, pc_next;

  pc_next_mux #(.TRAP_VEC(TRAP_VEC)) u_mux (
    .sel        (sel),
    .pc         (pcF),
    .target     (pc_targetE),
    .tgt_q      (tgt_q),
    .pc_next    (pc_next),
    .tgt_eff    (tgt_eff),
    .misaligned (misaligned)
  );

  assign imem.imem_req  = req_q;
  assign imem.imem_addr = pcF;
  assign pc_plus4F      = pcF + 32'd4;

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) state <= FPC_RUN;
    else     state <= state_n;
  end

  // Next state, PC source select and handshake-side outputs.
  always_comb begin
    beat      = req_q && imem.imem_ready;
    // HOLD ignores br_selE: execute holds a bubble after the flushE.
    acc       = br_selE && (state != FPC_HOLD) && !rst;
    state_n   = state;
    sel       = NPC_KEEP;
    latch_tgt = 1'b0;
    case (state)
      FPC_RUN, FPC_WAIT: begin
        if (acc) begin
          if (beat || !req_q) begin
            sel     = NPC_TGT;
            state_n = FPC_RUN;
          end else begin
            latch_tgt = 1'b1;
            state_n   = FPC_HOLD;
          end
        end else if (beat) begin
          sel     = stallF ? NPC_KEEP : NPC_SEQ;
          state_n = FPC_RUN;
        end else begin
          state_n = FPC_WAIT;
        end
      end
      FPC_HOLD: begin
        if (beat) begin
          sel     = NPC_TGTQ;
          state_n = FPC_RUN;
        end
      end
      default: state_n = FPC_RUN;
    endcase
    instr_validF = beat && !drop;
    flushE       = acc;
    flushD       = acc || ((state == FPC_HOLD) && beat);
    misalign_exc = TRAP_EN && acc && misaligned;
  end

  // PC, deferred-redirect target, drop flag and request valid.
  always_ff @(posedge clk) begin
    if (rst) begin
      pcF   <= RESET_PC;
      tgt_q <= 32'h0;
      drop  <= 1'b0;
      req_q <= 1'b0;
    end else begin
      pcF   <= pc_next;
      req_q <= 1'b1;
      if (latch_tgt) begin
        tgt_q <= tgt_eff;
        drop  <= 1'b1;
      end else if ((state == FPC_HOLD) && beat) begin
        drop  <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_fetch_pc_ctrl.sv
// Self-checking bench for fetch_pc_ctrl: directed scenarios followed by
// random stimulus, all checked each cycle against a transaction-level model.
`timescale 1ns/1ps
module tb_fetch_pc_ctrl;

  localparam logic [31:0] RST_PC = 32'h0000_0000;
  localparam logic [31:0] TRAPV  = 32'h0000_0100;
`ifdef MISALIGN_TRAP_EN
  localparam bit TRAP = 1'b1;
`else
  localparam bit TRAP = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst, br_selE, stallF;
  logic [31:0] pc_targetE;
  logic [31:0] pcF, pc_plus4F;
  logic        instr_validF, flushD, flushE, misalign_exc;

  fetch_pc_ctrl_if imem_if ();

  fetch_pc_ctrl #(.RESET_PC(RST_PC), .TRAP_VEC(TRAPV)) dut (
    .clk          (clk),
    .rst          (rst),
    .br_selE      (br_selE),
    .pc_targetE   (pc_targetE),
    .stallF       (stallF),
    .imem         (imem_if.master),
    .pcF          (pcF),
    .pc_plus4F    (pc_plus4F),
    .instr_validF (instr_validF),
    .flushD       (flushD),
    .flushE       (flushE),
    .misalign_exc (misalign_exc)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int fails  = 0;

  // Reference model: a fetch PC, whether a request is being issued, and at
  // most one redirect waiting for the outstanding beat.
  logic [31:0] m_pc   = RST_PC;
  logic        m_req  = 1'b0;
  logic        m_pend = 1'b0;
  logic [31:0] m_ptgt = 32'h0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      fails++;
      $display("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] eff_tgt(input logic [31:0] t);
    if (t[1:0] != 2'b00) return TRAP ? TRAPV : (t & ~32'h3);
    return t;
  endfunction

  // One clock: drive inputs, compare outputs to the model, advance the model.
  task automatic step(input logic r, input logic b, input logic [31:0] t,
                      input logic s, input logic rdy);
    logic mbeat, macc;
    @(negedge clk);
    rst = r; br_selE = b; pc_targetE = t; stallF = s; imem_if.imem_ready = rdy;
    #1;
    mbeat = m_req && rdy;
    macc  = b && !m_pend && !r;
    chk("pcF",       pcF,               m_pc);
    chk("imem_addr", imem_if.imem_addr, m_pc);
    chk("imem_req",  {31'b0, imem_if.imem_req}, {31'b0, m_req});
    chk("pc_plus4F", pc_plus4F,         m_pc + 32'd4);
    chk("instr_validF", {31'b0, instr_validF}, {31'b0, mbeat && !m_pend});
    chk("flushE",    {31'b0, flushE},   {31'b0, macc});
    chk("flushD",    {31'b0, flushD},   {31'b0, macc || (m_pend && mbeat)});
    chk("misalign_exc", {31'b0, misalign_exc},
        {31'b0, TRAP && macc && (t[1:0] != 2'b00)});
    if (r) begin
      m_pc = RST_PC; m_pend = 1'b0; m_ptgt = 32'h0; m_req = 1'b0;
    end else begin
      if (m_pend) begin
        if (mbeat) begin m_pc = m_ptgt; m_pend = 1'b0; end
      end else if (macc) begin
        if (mbeat || !m_req) m_pc = eff_tgt(t);
        else begin m_pend = 1'b1; m_ptgt = eff_tgt(t); end
      end else if (mbeat && !s) begin
        m_pc = m_pc + 32'd4;
      end
      m_req = 1'b1;
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic        b, s, rdy, r;
    logic [31:0] t;
    rst = 1'b1; br_selE = 1'b0; pc_targetE = 32'h0; stallF = 1'b0;
    imem_if.imem_ready = 1'b0;

    // Reset, then sequential fetch 0,4,8,C,10.
    step(1, 0, 0, 0, 1); step(1, 0, 0, 0, 1);
    chk("rst_pc", pcF, RST_PC);
    chk("rst_req", {31'b0, imem_if.imem_req}, 32'h0);
    step(0, 0, 0, 0, 1);
    chk("req_cycle1", {31'b0, imem_if.imem_req}, 32'h1);
    for (int i = 0; i < 4; i++) step(0, 0, 0, 0, 1);
    chk("seq_pc10", pcF, 32'h10);

    // Redirect on a beat.
    step(0, 1, 32'h200, 0, 1);
    chk("redir_pc", pcF, 32'h200);
    step(0, 0, 0, 0, 1);

    // Redirect with imem not ready: HOLD, address frozen, dropped beat.
    step(0, 1, 32'h20, 0, 1);
    step(0, 1, 32'h80, 0, 0);
    step(0, 0, 0, 0, 0);
    step(0, 1, 32'h500, 0, 0);
    chk("hold_addr", imem_if.imem_addr, 32'h20);
    step(0, 0, 0, 0, 1);
    chk("hold_tgt", pcF, 32'h80);

    // Redirect beats stall; stall alone holds.
    step(0, 1, 32'h40, 1, 1);
    chk("stall_redir", pcF, 32'h40);
    step(0, 0, 0, 1, 1);
    chk("stall_hold", pcF, 32'h40);

    // Misaligned target.
    step(0, 1, 32'h102, 0, 1);
    chk("misalign_pc", pcF, 32'h100);

    // Wrap, then reset while in HOLD.
    step(0, 1, 32'hFFFF_FFFC, 0, 1);
    step(0, 0, 0, 0, 1);
    chk("wrap_pc", pcF, 32'h0);
    step(0, 1, 32'h300, 0, 0);
    step(1, 0, 0, 0, 0);
    chk("hold_rst_pc", pcF, RST_PC);
    step(0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 1);

    // Random traffic.
    for (int i = 0; i < 600; i++) begin
      r   = ($urandom_range(0, 59) == 0);
      b   = !r && ($urandom_range(0, 5) == 0);
      t   = $urandom;
      if ($urandom_range(0, 3) != 0) t[1:0] = 2'b00;
      s   = ($urandom_range(0, 3) == 0);
      rdy = ($urandom_range(0, 2) != 0);
      step(r, b, t, s, rdy);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

endmodule
